// File: rtl/bus_arbiter_pkg.sv
// Shared types and address-decode helper for the bus arbiter.
// Build option: define BUS_TIMEOUT_EN to bound the ACCESS wait (see bus_arbiter).
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } bus_state_e;

  localparam logic [3:0]  DEV_BASE_OFFSET = 4'd2;
  localparam logic [31:0] DEV_ADDR_MASK   = 32'h0FFF_FFFF;

  typedef struct packed {
    logic        valid;
    logic [3:0]  idx;
    logic [31:0] offset;
  } dev_dec_t;

  // Top nibble selects the device (nibbles 0x0/0x1 are unmapped), low 28 bits are the offset.
  function automatic dev_dec_t dev_decode(input logic [31:0] addr, input int unsigned num_device);
    dev_dec_t dec;
    dec.offset = addr & DEV_ADDR_MASK;
    if (addr[31:28] < DEV_BASE_OFFSET) begin
      dec.valid = 1'b0;
      dec.idx   = 4'd0;
    end else begin
      dec.idx   = addr[31:28] - DEV_BASE_OFFSET;
      dec.valid = ({28'd0, dec.idx} < num_device);
    end
    return dec;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response and device-side select/ack signals of the bus arbiter.
interface bus_arbiter_if #(
  parameter int NUM_MASTER = 2,
  parameter int NUM_DEVICE = 14,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [NUM_MASTER-1:0]                 m_req_i;
  logic [NUM_MASTER-1:0]                 m_we_i;
  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0] m_rdata_o;
  logic [NUM_MASTER-1:0]                 m_gnt_o;
  logic [NUM_MASTER-1:0]                 m_err_o;

  logic [NUM_DEVICE-1:0]                 d_sel_o;
  logic [ADDR_WIDTH-1:0]                 d_addr_o;
  logic                                  d_we_o;
  logic                                  d_re_o;
  logic [DATA_WIDTH-1:0]                 d_wdata_o;
  logic [NUM_DEVICE-1:0][DATA_WIDTH-1:0] d_rdata_i;
  logic [NUM_DEVICE-1:0]                 d_ack_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, d_rdata_i, d_ack_i,
    output m_rdata_o, m_gnt_o, m_err_o, d_sel_o, d_addr_o, d_we_o, d_re_o, d_wdata_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, d_rdata_i, d_ack_i,
    input  m_rdata_o, m_gnt_o, m_err_o, d_sel_o, d_addr_o, d_we_o, d_re_o, d_wdata_o
  );

endinterface

// File: rtl/bus_arbiter_rr_arbiter.sv
// Round-robin request picker: first requester found scanning upward from rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_MASTER = 2,
  parameter int IDX_W      = 1
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic                  valid,
  output logic [IDX_W-1:0]      index
);

  assign valid = |req;

  // Scan from the farthest candidate back to rr_ptr so the nearest requester wins last.
  always_comb begin
    logic [IDX_W-1:0] cand_s;
    index  = '0;
    cand_s = '0;
    for (int i = NUM_MASTER - 1; i >= 0; i--) begin
      cand_s = IDX_W'((int'(rr_ptr) + i) % NUM_MASTER);
      index  = req[cand_s] ? cand_s : index;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-master to multi-device bus arbiter with address decode and round-robin fairness.
// Build option: BUS_TIMEOUT_EN turns an unanswered ACCESS into ERR after TIMEOUT_CYCLES.
module bus_arbiter #(
  parameter int NUM_MASTER     = 2,
  parameter int NUM_DEVICE     = 14,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bus_arbiter_if.slave  bus
);

  import bus_pkg::*;

  localparam int IDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
  localparam int DEV_W = (NUM_DEVICE > 1) ? $clog2(NUM_DEVICE) : 1;
  localparam logic [IDX_W-1:0]      LAST_MST = IDX_W'(NUM_MASTER - 1);
  localparam logic [NUM_MASTER-1:0] MST_ONE  = NUM_MASTER'(1);
  localparam logic [NUM_DEVICE-1:0] DEV_ONE  = NUM_DEVICE'(1);

  bus_state_e                            state_r;
  logic [IDX_W-1:0]                      rr_ptr_r;
  logic [IDX_W-1:0]                      mst_r;
  logic                                  we_r;
  logic [DEV_W-1:0]                      dev_r;
  logic [NUM_MASTER-1:0]                 m_gnt_r;
  logic [NUM_MASTER-1:0]                 m_err_r;
  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0] m_rdata_r;
  logic [NUM_DEVICE-1:0]                 d_sel_r;
  logic [ADDR_WIDTH-1:0]                 d_addr_r;
  logic                                  d_we_r;
  logic                                  d_re_r;
  logic [DATA_WIDTH-1:0]                 d_wdata_r;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  logic             arb_valid_s;
  logic [IDX_W-1:0] arb_idx_s;
  dev_dec_t         dec_s;

  rr_arbiter #(
    .NUM_MASTER (NUM_MASTER),
    .IDX_W      (IDX_W)
  ) u_rr_arbiter (
    .req    (bus.m_req_i),
    .rr_ptr (rr_ptr_r),
    .valid  (arb_valid_s),
    .index  (arb_idx_s)
  );

  assign dec_s = dev_decode(32'(bus.m_addr_i[arb_idx_s]), NUM_DEVICE);

  // Transaction FSM; every bus output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      mst_r     <= '0;
      we_r      <= 1'b0;
      dev_r     <= '0;
      m_gnt_r   <= '0;
      m_err_r   <= '0;
      m_rdata_r <= '0;
      d_sel_r   <= '0;
      d_addr_r  <= '0;
      d_we_r    <= 1'b0;
      d_re_r    <= 1'b0;
      d_wdata_r <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          m_gnt_r   <= '0;
          m_err_r   <= '0;
          m_rdata_r <= '0;
          if (arb_valid_s) begin
            mst_r <= arb_idx_s;
            we_r  <= bus.m_we_i[arb_idx_s];
            if (dec_s.valid) begin
              state_r   <= ACCESS;
              dev_r     <= dec_s.idx[DEV_W-1:0];
              d_sel_r   <= DEV_ONE << dec_s.idx;
              d_addr_r  <= ADDR_WIDTH'(dec_s.offset);
              d_we_r    <= bus.m_we_i[arb_idx_s];
              d_re_r    <= !bus.m_we_i[arb_idx_s];
              d_wdata_r <= bus.m_we_i[arb_idx_s] ? bus.m_wdata_i[arb_idx_s] : '0;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt_r <= '0;
`endif
            end else begin
              // Unmapped address: answer straight away with an error, devices stay idle.
              state_r <= ERR;
              m_gnt_r <= MST_ONE << arb_idx_s;
              m_err_r <= MST_ONE << arb_idx_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ACCESS: begin
          if (bus.d_ack_i[dev_r]) begin
            state_r          <= RESP;
            m_gnt_r          <= MST_ONE << mst_r;
            m_rdata_r[mst_r] <= we_r ? '0 : bus.d_rdata_i[dev_r];
            d_sel_r          <= '0;
            d_addr_r         <= '0;
            d_we_r           <= 1'b0;
            d_re_r           <= 1'b0;
            d_wdata_r        <= '0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            state_r   <= ERR;
            m_gnt_r   <= MST_ONE << mst_r;
            m_err_r   <= MST_ONE << mst_r;
            d_sel_r   <= '0;
            d_addr_r  <= '0;
            d_we_r    <= 1'b0;
            d_re_r    <= 1'b0;
            d_wdata_r <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
`else
          else begin
            state_r <= ACCESS;
          end
`endif
        end

        RESP, ERR: begin
          state_r   <= IDLE;
          m_gnt_r   <= '0;
          m_err_r   <= '0;
          m_rdata_r <= '0;
          rr_ptr_r  <= (mst_r == LAST_MST) ? '0 : mst_r + 1'b1;
        end

        default: begin
          state_r   <= IDLE;
          m_gnt_r   <= '0;
          m_err_r   <= '0;
          m_rdata_r <= '0;
          d_sel_r   <= '0;
          d_addr_r  <= '0;
          d_we_r    <= 1'b0;
          d_re_r    <= 1'b0;
          d_wdata_r <= '0;
        end
      endcase
    end
  end

  assign bus.m_gnt_o   = m_gnt_r;
  assign bus.m_err_o   = m_err_r;
  assign bus.m_rdata_o = m_rdata_r;
  assign bus.d_sel_o   = d_sel_r;
  assign bus.d_addr_o  = d_addr_r;
  assign bus.d_we_o    = d_we_r;
  assign bus.d_re_o    = d_re_r;
  assign bus.d_wdata_o = d_wdata_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_bus_arbiter;

  localparam int NM  = 2;
  localparam int ND  = 14;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ptr_m   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTER(NM), .NUM_DEVICE(ND), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_arbiter #(
    .NUM_MASTER(NM), .NUM_DEVICE(ND), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Reference model: round-robin winner scanning upward from the pointer.
  function automatic int pick(input logic [NM-1:0] req, input int ptr);
    for (int k = 0; k < NM; k++) begin
      if (req[(ptr + k) % NM]) return (ptr + k) % NM;
    end
    return -1;
  endfunction

  function automatic int dev_of(input logic [31:0] a);
    return int'(a[31:28]) - 2;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (dev_of(a) >= 0) && (dev_of(a) < ND);
  endfunction

  function automatic bit outs_zero();
    return (bus.m_gnt_o == '0) && (bus.m_err_o == '0) && (bus.m_rdata_o == '0) &&
           (bus.d_sel_o == '0) && (bus.d_addr_o == '0) && (bus.d_we_o == 1'b0) &&
           (bus.d_re_o == 1'b0) && (bus.d_wdata_o == '0);
  endfunction

  task automatic clear_inputs();
    bus.m_req_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.d_rdata_i = '0;
    bus.d_ack_i   = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ptr_m = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.m_req_i     = 2'b11;
    bus.m_addr_i[0] = 32'h2000_0000;
    bus.m_addr_i[1] = 32'h2000_0004;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (outs_zero() !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%h err=%h sel=%h, want all outputs 0", bus.m_gnt_o, bus.m_err_o, bus.d_sel_o);
      end
    end
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (outs_zero() !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: gnt=%h sel=%h, want all outputs 0", bus.m_gnt_o, bus.d_sel_o);
    end
    ptr_m = 0;
  endtask

  task automatic test_basic_read();
    bus.m_req_i     = 2'b01;
    bus.m_we_i      = 2'b00;
    bus.m_addr_i[0] = 32'h2000_0010;
    bus.d_rdata_i[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++;
    if (bus.d_sel_o !== 14'h0001 || bus.d_addr_o !== 32'h10 || bus.d_re_o !== 1'b1 || bus.d_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_access: sel=%h addr=%h re=%b we=%b, want 0001 10 1 0", bus.d_sel_o, bus.d_addr_o, bus.d_re_o, bus.d_we_o);
    end
    bus.d_ack_i = 14'h0001;
    @(negedge clk);
    bus.d_ack_i = '0;
    bus.m_req_i = '0;
    n_tests++;
    if (bus.m_gnt_o !== 2'b01 || bus.m_rdata_o[0] !== 32'hDEAD_BEEF || bus.m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_grant: gnt=%h rdata0=%h err=%h, want 01 deadbeef 00", bus.m_gnt_o, bus.m_rdata_o[0], bus.m_err_o);
    end
    ptr_m = 1;
    @(negedge clk);
    n_tests++;
    if (bus.m_gnt_o !== 2'b00 || bus.m_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL basic_pulse: gnt=%h rdata=%h, want 0 after one cycle", bus.m_gnt_o, bus.m_rdata_o);
    end
  endtask

  task automatic test_alternate();
    int seq[$];
    int exp_m;
    apply_reset();
    bus.m_req_i     = 2'b11;
    bus.m_addr_i[0] = 32'h2000_0000;
    bus.m_addr_i[1] = 32'h2000_0004;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.m_gnt_o == 2'b01) seq.push_back(0);
      else if (bus.m_gnt_o == 2'b10) seq.push_back(1);
      else if (bus.m_gnt_o != 2'b00) seq.push_back(99);
      bus.d_ack_i = bus.d_sel_o;
      if (c == 12) bus.m_req_i = '0;
    end
    bus.d_ack_i = '0;
    n_tests++;
    if (seq.size() !== 4) begin
      n_fail++;
      $display("FAIL alt_count: got %0d grants, want 4", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 4; i++) begin
      exp_m = ptr_m;
      ptr_m = (exp_m + 1) % NM;
      n_tests++;
      if (seq[i] !== exp_m) begin
        n_fail++;
        $display("FAIL alt_order[%0d]: got master %0d, want %0d", i, seq[i], exp_m);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_decode_err();
    bus.m_req_i     = 2'b10;
    bus.m_we_i      = 2'b10;
    bus.m_addr_i[1] = 32'h1000_0000;
    bus.m_wdata_i[1] = 32'h5555_AAAA;
    @(negedge clk);
    bus.m_req_i = '0;
    n_tests++;
    if (bus.m_gnt_o !== 2'b10 || bus.m_err_o !== 2'b10 || bus.d_sel_o !== '0 || bus.d_we_o !== 1'b0 || bus.m_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL decode_err: gnt=%h err=%h sel=%h we=%b, want 10 10 0 0", bus.m_gnt_o, bus.m_err_o, bus.d_sel_o, bus.d_we_o);
    end
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [NM-1:0]         req;
      logic [31:0]           a;
      logic                  we;
      logic [DW-1:0]         wd;
      logic [NM-1:0][DW-1:0] exp_vec;
      logic [ND-1:0]         noise;
      int                    w;
      int                    dev;
      int                    dly;
      req = NM'($urandom_range(1, (1 << NM) - 1));
      for (int m = 0; m < NM; m++) begin
        bus.m_addr_i[m]  = {4'($urandom_range(0, 15)), 28'($urandom)};
        bus.m_we_i[m]    = 1'($urandom);
        bus.m_wdata_i[m] = $urandom;
      end
      for (int d = 0; d < ND; d++) bus.d_rdata_i[d] = $urandom;
      bus.d_ack_i = '0;
      bus.m_req_i = req;
      w   = pick(req, ptr_m);
      a   = bus.m_addr_i[w];
      we  = bus.m_we_i[w];
      wd  = bus.m_wdata_i[w];
      dly = $urandom_range(0, 3);
      exp_vec = '0;
      if (addr_ok(a)) begin
        dev = dev_of(a);
        exp_vec[w] = we ? '0 : bus.d_rdata_i[dev];
        for (int c = 1; c <= dly + 1; c++) begin
          @(negedge clk);
          n_tests++;
          if (bus.d_sel_o !== (ND'(1) << dev) || bus.d_addr_o !== (a & 32'h0FFF_FFFF) ||
              bus.d_we_o !== we || bus.d_re_o !== !we || bus.d_wdata_o !== (we ? wd : '0) || bus.m_gnt_o !== '0) begin
            n_fail++;
            $display("FAIL rand_access t=%0d: sel=%h addr=%h we=%b wd=%h gnt=%h, want sel=%h addr=%h we=%b wd=%h gnt=0",
                     t, bus.d_sel_o, bus.d_addr_o, bus.d_we_o, bus.d_wdata_o, bus.m_gnt_o,
                     ND'(1) << dev, a & 32'h0FFF_FFFF, we, we ? wd : '0);
          end
          noise = ND'($urandom);
          noise[dev] = 1'b0;
          bus.d_ack_i = (c == dly + 1) ? (ND'(1) << dev) : noise;
        end
        @(negedge clk);
        bus.d_ack_i = '0;
        bus.m_req_i = '0;
        n_tests++;
        if (bus.m_gnt_o !== (NM'(1) << w) || bus.m_err_o !== '0 || bus.m_rdata_o !== exp_vec || bus.d_sel_o !== '0) begin
          n_fail++;
          $display("FAIL rand_resp t=%0d: gnt=%h err=%h rdata=%h, want gnt=%h err=0 rdata=%h",
                   t, bus.m_gnt_o, bus.m_err_o, bus.m_rdata_o, NM'(1) << w, exp_vec);
        end
      end else begin
        @(negedge clk);
        bus.m_req_i = '0;
        n_tests++;
        if (bus.m_gnt_o !== (NM'(1) << w) || bus.m_err_o !== (NM'(1) << w) || bus.m_rdata_o !== '0 || bus.d_sel_o !== '0) begin
          n_fail++;
          $display("FAIL rand_err t=%0d: gnt=%h err=%h sel=%h, want gnt=err=%h sel=0",
                   t, bus.m_gnt_o, bus.m_err_o, bus.d_sel_o, NM'(1) << w);
        end
      end
      ptr_m = (w + 1) % NM;
      @(negedge clk);
      n_tests++;
      if (outs_zero() !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_idle t=%0d: gnt=%h err=%h sel=%h, want all 0", t, bus.m_gnt_o, bus.m_err_o, bus.d_sel_o);
      end
    end
  endtask

  task automatic test_timeout();
    int acc;
    int gnt_seen;
    int err_at;
    acc      = 0;
    gnt_seen = 0;
    err_at   = -1;
    bus.m_req_i     = 2'b01;
    bus.m_we_i      = 2'b00;
    bus.m_addr_i[0] = 32'h3000_0000;
    bus.d_rdata_i[1] = 32'hCAFE_F00D;
    bus.d_ack_i     = '0;
`ifdef BUS_TIMEOUT_EN
    for (int c = 1; c <= 40 && err_at < 0; c++) begin
      @(negedge clk);
      if (bus.m_err_o != '0) err_at = c;
      else if (bus.d_sel_o != '0) acc++;
    end
    bus.m_req_i = '0;
    n_tests++;
    if (err_at !== TMO + 1 || acc !== TMO || bus.m_err_o !== 2'b01 || bus.m_gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout: err at cycle %0d after %0d access cycles, err=%h gnt=%h, want cycle %0d after %0d, 01 01",
               err_at, acc, bus.m_err_o, bus.m_gnt_o, TMO + 1, TMO);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.m_gnt_o != '0 || bus.m_err_o != '0) gnt_seen++;
    end
    n_tests++;
    if (gnt_seen !== 0 || bus.d_sel_o !== 14'h0002) begin
      n_fail++;
      $display("FAIL no_timeout_wait: %0d early responses, sel=%h, want 0 and sel=0002", gnt_seen, bus.d_sel_o);
    end
    bus.d_ack_i = 14'h0002;
    @(negedge clk);
    bus.d_ack_i = '0;
    bus.m_req_i = '0;
    n_tests++;
    if (bus.m_gnt_o !== 2'b01 || bus.m_err_o !== 2'b00 || bus.m_rdata_o[0] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL late_ack: gnt=%h err=%h rdata0=%h, want 01 00 cafef00d", bus.m_gnt_o, bus.m_err_o, bus.m_rdata_o[0]);
    end
`endif
    ptr_m = 1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int gnt_seen;
    gnt_seen = 0;
    bus.m_req_i     = 2'b10;
    bus.m_we_i      = 2'b00;
    bus.m_addr_i[1] = 32'h2000_0000;
    @(negedge clk);
    n_tests++;
    if (bus.d_sel_o !== 14'h0001) begin
      n_fail++;
      $display("FAIL midrst_access: sel=%h, want 0001", bus.d_sel_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (outs_zero() !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_clear: gnt=%h sel=%h, want all outputs 0", bus.m_gnt_o, bus.d_sel_o);
    end
    bus.d_ack_i = 14'h0001;
    repeat (2) begin
      @(negedge clk);
      if (bus.m_gnt_o != '0) gnt_seen++;
    end
    clear_inputs();
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    if (bus.m_gnt_o != '0) gnt_seen++;
    n_tests++;
    if (gnt_seen !== 0) begin
      n_fail++;
      $display("FAIL midrst_nogrant: %0d grant pulses seen, want 0", gnt_seen);
    end
    bus.m_req_i      = 2'b11;
    bus.m_addr_i[0]  = 32'h2000_0020;
    bus.m_addr_i[1]  = 32'h2000_0030;
    bus.d_rdata_i[0] = 32'h1234_5678;
    @(negedge clk);
    n_tests++;
    if (bus.d_sel_o !== 14'h0001 || bus.d_addr_o !== 32'h20) begin
      n_fail++;
      $display("FAIL midrst_first: sel=%h addr=%h, want 0001 20 (master 0 first)", bus.d_sel_o, bus.d_addr_o);
    end
    bus.d_ack_i = 14'h0001;
    @(negedge clk);
    bus.d_ack_i = '0;
    bus.m_req_i = '0;
    n_tests++;
    if (bus.m_gnt_o !== (NM'(1) << pick(2'b11, ptr_m)) || bus.m_rdata_o[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL midrst_service: gnt=%h rdata0=%h, want 01 12345678", bus.m_gnt_o, bus.m_rdata_o[0]);
    end
    ptr_m = 1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_read();
    test_alternate();
    test_decode_err();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
